// File: rtl/acc_readout_engine.sv
// acc_readout_engine
// ------------------
// Read-side master for the double-buffered accumulator memory. A drain command
// (base address, word count) is turned into a run of accumulator read strobes.
// The accumulator's 1-cycle registered read latency is absorbed, and the
// returned words are streamed to the post-processing pipeline over a
// valid/ready interface that supports full backpressure. The accumulator buffer
// select is owned elsewhere and is not driven here.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   drain command handshake (ready only while idle)
//   cmd_base_addr         first accumulator address (wraps modulo 2^ADDR_W)
//   cmd_len               word count, 0 .. 2^ADDR_W
//   acc_rd_en/acc_rd_addr accumulator read strobe and address
//   acc_rd_data           accumulator read data, valid 1 cycle after acc_rd_en
//   out_valid/out_ready   output stream handshake
//   out_data/out_last     output word (unmodified) and end-of-command marker
//   busy                  high from command acceptance until back in idle
//   done                  single-cycle completion pulse
//
// FSM states
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | cmd_ready=1, waiting for a drain command
//   S_RUN   | issuing accumulator reads, gated by output credit
//   S_DRAIN | all reads issued; waiting for the final beat to handshake
//   S_DONE  | done pulses for exactly one cycle, then back to idle

module acc_readout_engine #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              acc_rd_en,
  output logic [ADDR_W-1:0] acc_rd_addr,
  input  logic [DATA_W-1:0] acc_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;

  // A read issued this cycle returns data next cycle; pending marks that slot.
  logic               pending;
  logic               pending_last;

  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic               push;
  logic               pop;
  logic               last_issue;
  logic [CNT_W:0]     in_flight;
  logic [CNT_W:0]     credit_lim;
  logic               have_credit;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid && fifo_last[rd_ptr];

  assign pop  = out_valid && out_ready;
  assign push = pending;

  // Credit: words already in the FIFO plus the one in flight, less the one
  // leaving this cycle, must leave room for the read being considered. This
  // is what makes FIFO overflow impossible without any overflow check.
  assign in_flight   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pending};
  assign credit_lim  = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign have_credit = (in_flight < credit_lim);

  assign last_issue = ((issued + LEN_W'(1)) == len_q);
  assign acc_rd_en  = (state == S_RUN) && (issued < len_q) && have_credit;

  // Read-latency tracking: tags the returning word and its last marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      pending      <= acc_rd_en;
      pending_last <= acc_rd_en && last_issue;
    end
  end

  // Output skid FIFO. acc_rd_data is only ever captured behind pending, so the
  // stale value the accumulator holds between reads never enters the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= acc_rd_data;
        fifo_last[wr_ptr] <= pending_last;
        wr_ptr            <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Control FSM. done is a registered output: on the normal path it is set on
  // the same edge that takes the final beat, so it shows in the following
  // cycle. A zero-length command enters S_DONE with done still low and spends
  // one cycle raising it, so done always lasts one cycle before idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_q       <= '0;
      issued      <= '0;
      acc_rd_addr <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            acc_rd_addr <= cmd_base_addr;
            len_q       <= cmd_len;
            issued      <= '0;
            state       <= (cmd_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (acc_rd_en) begin
            issued      <= issued + LEN_W'(1);
            acc_rd_addr <= acc_rd_addr + ADDR_W'(1);
            if (last_issue) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The beat carrying out_last is the only word left once it is at
          // the head, so taking it empties both FIFO and read pipeline.
          if (pop && out_last && !pending && (fifo_count == CNT_W'(1))) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (done) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_readout_engine.sv
// Bench for acc_readout_engine: an accumulator memory model with registered
// read, a monitor recording reads and output beats per command, and a
// reference built from the command rules (word i of a drain comes from
// address (base + i) mod 256, last flag on word len-1).

module tb_acc_readout_engine;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 64;
  localparam int FIFO_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_addr = '0;
  logic [ADDR_W:0]   cmd_len = '0;
  logic              acc_rd_en;
  logic [ADDR_W-1:0] acc_rd_addr;
  logic [DATA_W-1:0] acc_rd_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  acc_readout_engine #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_len      (cmd_len),
    .acc_rd_en    (acc_rd_en),
    .acc_rd_addr  (acc_rd_addr),
    .acc_rd_data  (acc_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Accumulator model: registered read, holds its last value when not read.
  logic [63:0] acc_mem [256];
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
  end

  // Consumer ready: fixed level or random per cycle.
  bit rdy_rand  = 1'b0;
  bit rdy_fixed = 1'b1;
  always @(posedge clk) begin
    #2;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    else          out_ready = rdy_fixed;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor (sole writer of the per-command record).
  int          n_acc = 0;
  int          acc_cyc = 0;
  logic [7:0]  rd_q[$];
  int          rd_cyc_q[$];
  logic [64:0] out_q[$];
  int          pop_cyc_q[$];
  int          first_valid_cyc = -1;
  int          n_done = 0;
  int          done_cyc = -1;
  int          ready_cyc = -1;
  int          n_rd_tot = 0;
  int          n_pop_tot = 0;
  int          max_inflight = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_rd_tot  = 0;
      n_pop_tot = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        acc_cyc = cyc;
        rd_q.delete(); rd_cyc_q.delete(); out_q.delete(); pop_cyc_q.delete();
        first_valid_cyc = -1; n_done = 0; done_cyc = -1; ready_cyc = -1;
        n_rd_tot = 0; n_pop_tot = 0; max_inflight = 0;
      end
      if (acc_rd_en) begin
        rd_q.push_back(acc_rd_addr);
        rd_cyc_q.push_back(cyc);
        n_rd_tot++;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        out_q.push_back({out_last, out_data});
        pop_cyc_q.push_back(cyc);
        n_pop_tot++;
      end
      if (n_rd_tot - n_pop_tot > max_inflight) max_inflight = n_rd_tot - n_pop_tot;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (cmd_ready && n_done > 0 && ready_cyc < 0) ready_cyc = cyc;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the engine idle; returns at posedge+1 of the
  // cycle after the acceptance edge.
  task automatic start_cmd(input logic [7:0] base, input logic [8:0] len);
    int acc_before;
    acc_before    = n_acc;
    cmd_valid     = 1'b1;
    cmd_base_addr = base;
    cmd_len       = len;
    @(negedge clk); #1;
    check("cmd_accept", n_acc, acc_before + 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input logic [7:0] base,
                            input logic [8:0] len, input bit consec);
    int         n;
    int         n_last;
    logic [7:0] ea;
    n = int'(len);
    for (int k = 0; k < 4000 && ready_cyc < 0; k++) begin
      @(posedge clk); #1;
    end
    check({tag, " done_seen"}, ready_cyc >= 0, 1);
    check({tag, " n_done"}, n_done, 1);
    check({tag, " n_reads"}, rd_q.size(), n);
    check({tag, " n_words"}, out_q.size(), n);
    check({tag, " inflight_le_depth"}, max_inflight <= FIFO_DEPTH, 1);
    for (int i = 0; i < n && i < rd_q.size(); i++) begin
      ea = base + 8'(i);
      check({tag, " rd_addr"}, rd_q[i], ea);
    end
    n_last = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (out_q[i][64]) n_last++;
    end
    check({tag, " n_last"}, n_last, (n > 0) ? 1 : 0);
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      ea = base + 8'(i);
      check({tag, " data"}, out_q[i][63:0], acc_mem[ea]);
      check({tag, " last"}, out_q[i][64], (i == n - 1) ? 1 : 0);
    end
    if (n > 0) begin
      if (rd_cyc_q.size() > 0) check({tag, " first_rd_cyc"}, rd_cyc_q[0], acc_cyc + 1);
      check({tag, " first_valid_cyc"}, first_valid_cyc, acc_cyc + 3);
      if (pop_cyc_q.size() > 0)
        check({tag, " done_cyc"}, done_cyc, pop_cyc_q[pop_cyc_q.size() - 1] + 1);
    end else begin
      check({tag, " zero_done_cyc"}, done_cyc, acc_cyc + 2);
      check({tag, " zero_no_valid"}, first_valid_cyc, -1);
    end
    check({tag, " ready_cyc"}, ready_cyc, done_cyc + 1);
    if (consec) begin
      for (int i = 0; i < rd_cyc_q.size(); i++)
        check({tag, " rd_cyc"}, rd_cyc_q[i], acc_cyc + 1 + i);
      for (int i = 0; i < pop_cyc_q.size(); i++)
        check({tag, " pop_cyc"}, pop_cyc_q[i], acc_cyc + 3 + i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [63:0] d0;
    int          acc_before;
    logic [7:0]  rb;
    logic [8:0]  rl;

    for (int i = 0; i < 256; i++) acc_mem[i] = {$urandom(), $urandom()};
    for (int i = 0; i < 4; i++) acc_mem[16 + i] = 64'h0123_4567_89AB_CDA0 + 64'(i);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd_ready", cmd_ready, 1);
    check("rst acc_rd_en", acc_rd_en, 0);
    check("rst acc_rd_addr", acc_rd_addr, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_last", out_last, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    start_cmd(8'h10, 9'd4);
    finish_cmd("basic", 8'h10, 9'd4, 1'b1);

    start_cmd(8'hFE, 9'd4);
    finish_cmd("wrap", 8'hFE, 9'd4, 1'b1);

    // Backpressure: consumer stalls for 6 cycles from the first valid word.
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    start_cmd(8'h40, 9'd8);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("bp first_valid_seen", found, 1);
    check("bp reads_before_stall", n_rd_tot <= 2, 1);
    d0 = out_data;
    check("bp first_word", d0, acc_mem[8'h40]);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      check("bp stall_rd_en", acc_rd_en, 0);
      check("bp stall_valid", out_valid, 1);
      check("bp stall_data", out_data, d0);
      check("bp stall_last", out_last, 0);
    end
    @(posedge clk); #1;
    rdy_fixed = 1'b1;
    finish_cmd("backpressure", 8'h40, 9'd8, 1'b0);

    start_cmd(8'h00, 9'd0);
    finish_cmd("zero_len", 8'h00, 9'd0, 1'b1);

    start_cmd(8'hFF, 9'd1);
    finish_cmd("len1", 8'hFF, 9'd1, 1'b1);

    // Commands offered while busy must be ignored.
    acc_before = n_acc;
    start_cmd(8'h20, 9'd16);
    for (int k = 0; k < 3; k++) begin
      cmd_valid     = 1'b1;
      cmd_base_addr = 8'h55;
      cmd_len       = 9'd3;
      @(negedge clk); #1;
      check("busy cmd_ready", cmd_ready, 0);
      check("busy busy", busy, 1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    finish_cmd("busy", 8'h20, 9'd16, 1'b1);
    check("busy single_accept", n_acc, acc_before + 1);

    rdy_rand = 1'b1;
    start_cmd(8'h80, 9'd256);
    finish_cmd("full", 8'h80, 9'd256, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rb = 8'($urandom_range(0, 255));
      rl = 9'($urandom_range(1, 40));
      start_cmd(rb, rl);
      finish_cmd("random", rb, rl, 1'b0);
    end
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a drain.
    start_cmd(8'h30, 9'd10);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (n_pop_tot >= 3) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rst_mid three_beats", found, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid out_valid", out_valid, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid acc_rd_en", acc_rd_en, 0);
    check("rst_mid cmd_ready", cmd_ready, 1);
    check("rst_mid out_last", out_last, 0);
    check("rst_mid acc_rd_addr", acc_rd_addr, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid no_done", n_done, 0);
    check("rst_mid idle_ready", cmd_ready, 1);

    start_cmd(8'h3E, 9'd2);
    finish_cmd("post_rst", 8'h3E, 9'd2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
